// File: rtl/sr_latch_driver_pkg.sv
// Shared definitions for the SR latch driver.
//   state_t      : FSM states (IDLE/PULSE/GAP/CHECK)
//   CMD_SET/CLR  : legal command encodings; every other value is illegal
//   cmd_is_legal : helper that classifies a command
package sr_drv_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PULSE,
        ST_GAP,
        ST_CHECK
    } state_t;

    localparam logic [1:0] CMD_SET = 2'b01;
    localparam logic [1:0] CMD_CLR = 2'b10;

    function automatic logic cmd_is_legal(input logic [1:0] c);
        return (c == CMD_SET) || (c == CMD_CLR);
    endfunction

endpackage

// File: rtl/sr_latch_driver_if.sv
// Bus between the command source / latch and the SR latch driver.
//   cmd_valid, cmd  : command request (master -> driver)
//   cmd_ready       : driver idle and able to accept
//   S_n, R_n        : active-low drive to the NAND latch
//   q_fb            : latch Q readback, asynchronous to clk
//   busy/done/err   : status; done and err are one-cycle pulses
interface sr_latch_driver_if;
    logic       cmd_valid;
    logic [1:0] cmd;
    logic       cmd_ready;
    logic       S_n;
    logic       R_n;
    logic       q_fb;
    logic       busy;
    logic       done;
    logic       err;

    modport master (
        output cmd_valid, cmd, q_fb,
        input  cmd_ready, S_n, R_n, busy, done, err
    );

    modport slave (
        input  cmd_valid, cmd, q_fb,
        output cmd_ready, S_n, R_n, busy, done, err
    );
endinterface

// File: rtl/sr_latch_driver_sync_2ff.sv
// Two-flop synchronizer for the asynchronous latch readback.
//   clk, rst : clock and synchronous active-high reset (flops clear to 0)
//   d        : asynchronous input
//   q        : synchronized output, two cycles of latency
module sync_2ff (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);
    logic s1_q, s1_d;
    logic s2_q, s2_d;

    always_comb begin
        s1_d = d;
        s2_d = s1_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
        end else begin
            s1_q <= s1_d;
            s2_q <= s2_d;
        end
    end

    assign q = s2_q;
endmodule

// File: rtl/sr_latch_driver.sv
// Clocked driver for the active-low S_n/R_n inputs of a NAND SR latch.
// Each accepted SET/CLEAR becomes a PULSE_CYC-long low pulse on one line,
// followed by GAP_CYC cycles with both lines high, then a one-cycle check of
// the synchronized latch Q against the commanded value.
//   clk, rst : clock, synchronous active-high reset
//   bus      : command / latch / status signals (slave side)
module sr_latch_driver
    import sr_drv_pkg::*;
#(
    parameter int unsigned PULSE_CYC = 4,
    parameter int unsigned GAP_CYC   = 2,
    parameter int unsigned CNT_W     = 4
) (
    input  logic              clk,
    input  logic              rst,
    sr_latch_driver_if.slave  bus
);
    localparam int unsigned MAX_LOAD =
        ((PULSE_CYC > GAP_CYC) ? PULSE_CYC : GAP_CYC) - 1;

    if (PULSE_CYC < 1 || GAP_CYC < 2 || MAX_LOAD > (2 ** CNT_W) - 1) begin : g_param_check
        $error("sr_latch_driver: bad PULSE_CYC/GAP_CYC/CNT_W combination");
    end

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               exp_q, exp_d;
    logic               s_n_q, s_n_d;
    logic               r_n_q, r_n_d;
    logic               done_q, done_d;
    logic               err_q, err_d;
    logic               ready_q, ready_d;
    logic               q_sync;

    sync_2ff u_sync (
        .clk (clk),
        .rst (rst),
        .d   (bus.q_fb),
        .q   (q_sync)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        exp_d   = exp_q;
        s_n_d   = s_n_q;
        r_n_d   = r_n_q;
        done_d  = 1'b0;
        err_d   = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (bus.cmd_valid && ready_q) begin
                    if (cmd_is_legal(bus.cmd)) begin
                        exp_d   = (bus.cmd == CMD_SET);
                        s_n_d   = (bus.cmd != CMD_SET);
                        r_n_d   = (bus.cmd != CMD_CLR);
                        cnt_d   = CNT_W'(PULSE_CYC - 1);
                        state_d = ST_PULSE;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            ST_PULSE: begin
                if (cnt_q == '0) begin
                    s_n_d   = 1'b1;
                    r_n_d   = 1'b1;
                    cnt_d   = CNT_W'(GAP_CYC - 1);
                    state_d = ST_GAP;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_GAP: begin
                if (cnt_q == '0) begin
                    state_d = ST_CHECK;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_CHECK: begin
                done_d  = 1'b1;
                err_d   = (q_sync != exp_q);
                state_d = ST_IDLE;
            end
            default: begin
                s_n_d   = 1'b1;
                r_n_d   = 1'b1;
                state_d = ST_IDLE;
            end
        endcase

        // Registered so that ready stays low through reset and rises at the
        // first edge after release, and is already high alongside done.
        ready_d = (state_d == ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            exp_q   <= 1'b0;
            s_n_q   <= 1'b1;
            r_n_q   <= 1'b1;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            exp_q   <= exp_d;
            s_n_q   <= s_n_d;
            r_n_q   <= r_n_d;
            done_q  <= done_d;
            err_q   <= err_d;
            ready_q <= ready_d;
        end
    end

    assign bus.S_n       = s_n_q;
    assign bus.R_n       = r_n_q;
    assign bus.done      = done_q;
    assign bus.err       = err_q;
    assign bus.cmd_ready = ready_q;
    assign bus.busy      = (state_q != ST_IDLE);
endmodule

// File: tb/tb_sr_latch_driver.sv
// Self-checking bench for sr_latch_driver: directed vector table, hand
// sequences for reset and busy corner cases, and randomized traffic checked
// against a timeline model derived from the accept cycle.
module tb_sr_latch_driver;
    localparam int P      = 4;
    localparam int G      = 2;
    localparam int W      = 4;
    localparam int DONE_N = P + G + 1;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    sr_latch_driver_if bus ();

    sr_latch_driver #(.PULSE_CYC(P), .GAP_CYC(G), .CNT_W(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // NAND latch model for the readback, or a stuck value.
    logic use_latch;
    logic stuck_val;
    logic lat_q = 1'b0;
    always @(bus.S_n or bus.R_n) begin
        if (bus.S_n === 1'b0)      lat_q = 1'b1;
        else if (bus.R_n === 1'b0) lat_q = 1'b0;
    end
    assign bus.q_fb = use_latch ? lat_q : stuck_val;

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input int act, input int expv);
        tests++;
        if (act != expv) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, expv);
        end
    endtask

    // Continuous invariants: never both lines low, done never two cycles.
    logic mon_en = 1'b0;
    int   inv_bad = 0;
    logic prev_done = 1'b0;
    always @(negedge clk) begin
        if (mon_en) begin
            if ((bus.S_n | bus.R_n) !== 1'b1) inv_bad++;
            if (bus.done === 1'b1 && prev_done) inv_bad++;
            prev_done = (bus.done === 1'b1);
        end
    end

    typedef struct {
        logic [1:0] cmd;
        logic       use_latch;
        logic       stuck;
        int         s_low;
        int         r_low;
        int         done_at;
        int         err_at;
        int         err_cnt;
        int         busy0;
    } vec_t;

    vec_t vecs[7];

    task automatic run_vec(input vec_t v, input string nm);
        int s_low = 0, r_low = 0, done_cnt = 0, err_cnt = 0;
        int done_at = -1, err_at = -1, busy0 = -1, ready0 = -1, ready_done = -1;
        use_latch = v.use_latch;
        stuck_val = v.stuck;
        repeat (3) @(negedge clk);
        check({nm, " ready_before"}, int'(bus.cmd_ready), 1);
        bus.cmd       = v.cmd;
        bus.cmd_valid = 1'b1;
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        bus.cmd       = 2'b00;
        for (int n = 0; n < 14; n++) begin
            if (n > 0) @(negedge clk);
            if (n == 0) begin
                busy0  = int'(bus.busy);
                ready0 = int'(bus.cmd_ready);
            end
            if (!bus.S_n) s_low++;
            if (!bus.R_n) r_low++;
            if (bus.done) begin
                done_cnt++;
                if (done_at < 0) begin
                    done_at    = n;
                    ready_done = int'(bus.cmd_ready);
                end
            end
            if (bus.err) begin
                err_cnt++;
                if (err_at < 0) err_at = n;
            end
        end
        check({nm, " s_low_cycles"}, s_low, v.s_low);
        check({nm, " r_low_cycles"}, r_low, v.r_low);
        check({nm, " done_at"}, done_at, v.done_at);
        check({nm, " done_count"}, done_cnt, (v.done_at >= 0) ? 1 : 0);
        check({nm, " err_at"}, err_at, v.err_at);
        check({nm, " err_count"}, err_cnt, v.err_cnt);
        check({nm, " busy_first"}, busy0, v.busy0);
        check({nm, " ready_first"}, ready0, 1 - v.busy0);
        if (v.done_at >= 0) check({nm, " ready_with_done"}, ready_done, 1);
    endtask

    // Random-traffic reference: outputs follow from the cycle distance to
    // the last accepted legal command.
    task automatic run_random(input int ncyc, input string nm);
        logic       m_ready = 1'b1, m_act = 1'b0, m_set = 1'b0, m_mis = 1'b0;
        int         cyc = 0, m_c0 = 0, d;
        logic       acc, ill_now, e_sn, e_rn, e_busy, e_done, e_err;
        logic [1:0] c;
        for (int i = 0; i < ncyc; i++) begin
            c             = 2'($urandom_range(0, 3));
            bus.cmd       = c;
            bus.cmd_valid = ($urandom_range(0, 3) == 0);
            @(posedge clk);
            cyc++;
            acc     = bus.cmd_valid && m_ready;
            ill_now = 1'b0;
            if (acc) begin
                if (c == 2'b01 || c == 2'b10) begin
                    m_act = 1'b1;
                    m_c0  = cyc;
                    m_set = (c == 2'b01);
                    m_mis = !use_latch && (stuck_val != m_set);
                end else begin
                    ill_now = 1'b1;
                end
            end
            d      = cyc - m_c0;
            e_sn   = !(m_act && m_set && d < P);
            e_rn   = !(m_act && !m_set && d < P);
            e_busy = m_act && d <= P + G;
            e_done = m_act && d == DONE_N;
            e_err  = ill_now || (e_done && m_mis);
            if (e_done) m_act = 1'b0;
            m_ready = !e_busy;
            @(negedge clk);
            check($sformatf("%s cyc%0d {S_n,R_n,busy,ready,done,err}", nm, cyc),
                  int'({bus.S_n, bus.R_n, bus.busy, bus.cmd_ready, bus.done, bus.err}),
                  int'({e_sn, e_rn, e_busy, !e_busy, e_done, e_err}));
        end
        bus.cmd_valid = 1'b0;
        repeat (12) @(negedge clk);
    endtask

    initial begin
        int cnt;
        rst           = 1'b1;
        bus.cmd_valid = 1'b0;
        bus.cmd       = 2'b00;
        use_latch     = 1'b1;
        stuck_val     = 1'b0;

        // Reset: three cycles held.
        repeat (3) @(negedge clk);
        mon_en = 1'b1;
        check("reset S_n", int'(bus.S_n), 1);
        check("reset R_n", int'(bus.R_n), 1);
        check("reset done", int'(bus.done), 0);
        check("reset err", int'(bus.err), 0);
        check("reset busy", int'(bus.busy), 0);
        check("reset cmd_ready", int'(bus.cmd_ready), 0);
        rst = 1'b0;
        @(negedge clk);
        check("post-reset cmd_ready", int'(bus.cmd_ready), 1);

        vecs[0] = '{2'b01, 1'b1, 1'b0, P, 0, DONE_N, -1, 0, 1};
        vecs[1] = '{2'b10, 1'b1, 1'b0, 0, P, DONE_N, -1, 0, 1};
        vecs[2] = '{2'b10, 1'b0, 1'b1, 0, P, DONE_N, DONE_N, 1, 1};
        vecs[3] = '{2'b01, 1'b0, 1'b0, P, 0, DONE_N, DONE_N, 1, 1};
        vecs[4] = '{2'b01, 1'b0, 1'b1, P, 0, DONE_N, -1, 0, 1};
        vecs[5] = '{2'b11, 1'b1, 1'b0, 0, 0, -1, 0, 1, 0};
        vecs[6] = '{2'b00, 1'b1, 1'b0, 0, 0, -1, 0, 1, 0};
        for (int i = 0; i < 7; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

        // CLEAR arriving at T3 of a SET is ignored.
        use_latch = 1'b1;
        repeat (2) @(negedge clk);
        bus.cmd = 2'b01; bus.cmd_valid = 1'b1;
        @(negedge clk);                      // n=0
        bus.cmd_valid = 1'b0;
        begin
            int s_low = 0, r_low = 0, dn = 0, er = 0;
            for (int n = 0; n < 14; n++) begin
                if (n > 0) @(negedge clk);
                if (n == 2) begin bus.cmd = 2'b10; bus.cmd_valid = 1'b1; end
                if (n == 3) bus.cmd_valid = 1'b0;
                if (!bus.S_n) s_low++;
                if (!bus.R_n) r_low++;
                if (bus.done) dn++;
                if (bus.err) er++;
            end
            check("busy_ignore s_low", s_low, P);
            check("busy_ignore r_low", r_low, 0);
            check("busy_ignore done_count", dn, 1);
            check("busy_ignore err_count", er, 0);
        end

        // Reset applied at T2 of a SET aborts it without done/err.
        repeat (2) @(negedge clk);
        bus.cmd = 2'b01; bus.cmd_valid = 1'b1;
        @(negedge clk);                      // n=0
        bus.cmd_valid = 1'b0;
        check("midrst S_n low before reset", int'(bus.S_n), 0);
        @(negedge clk);                      // n=1
        rst = 1'b1;
        @(negedge clk);                      // after edge T2
        check("midrst S_n", int'(bus.S_n), 1);
        check("midrst R_n", int'(bus.R_n), 1);
        check("midrst busy", int'(bus.busy), 0);
        check("midrst cmd_ready", int'(bus.cmd_ready), 0);
        rst = 1'b0;
        cnt = 0;
        for (int n = 0; n < 10; n++) begin
            @(negedge clk);
            if (bus.done || bus.err) cnt++;
        end
        check("midrst no done/err", cnt, 0);
        run_vec(vecs[0], "after_midrst_set");

        // Randomized traffic in three readback modes.
        use_latch = 1'b1;
        repeat (3) @(negedge clk);
        run_random(300, "rnd_latch");
        use_latch = 1'b0; stuck_val = 1'b0;
        repeat (3) @(negedge clk);
        run_random(300, "rnd_stuck0");
        stuck_val = 1'b1;
        repeat (3) @(negedge clk);
        run_random(300, "rnd_stuck1");

        check("invariants S_n|R_n and single-cycle done", inv_bad, 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
